// File: rtl/mult_issue_arbiter.sv
// mult_issue_arbiter: shares one fixed-latency integer multiplier between
// NUM_REQ multiply reservation stations. A round-robin pick latches the
// winner's operands and tag, the multiply is sequenced for NUM_CYCLES cycles,
// and the product is held on the CDB-side port until res_ready accepts it.
// Optional feature macro: MULT_ARB_HIGH_EN adds req_hi to select the upper
// half of the unsigned product (MULHU) per request.
module mult_issue_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int TAG_WIDTH  = 5,
    parameter int NUM_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   op_b,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
`ifdef MULT_ARB_HIGH_EN
    input  logic [NUM_REQ-1:0]              req_hi,
`endif
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy,
    output logic                            res_valid,
    output logic [DATA_WIDTH-1:0]           res_data,
    output logic [TAG_WIDTH-1:0]            res_tag,
    input  logic                            res_ready
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 next_state_s;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [DATA_WIDTH-1:0]  a_r;
    logic [DATA_WIDTH-1:0]  b_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [DATA_WIDTH-1:0]  product_s;
    logic [PTR_W-1:0]       win_idx_s;
    logic [PTR_W-1:0]       cand_s;
    logic                   win_found_s;
    logic                   accept_s;
    logic [PTR_W-1:0]       next_ptr_s;
    int                     idx_v;
`ifdef MULT_ARB_HIGH_EN
    logic                   hi_r;
    logic [2*DATA_WIDTH-1:0] full_prod_s;
`endif

    // Round-robin scan: first requesting station at or after rr_ptr.
    always_comb begin
        win_idx_s   = {PTR_W{1'b0}};
        win_found_s = 1'b0;
        cand_s      = {PTR_W{1'b0}};
        idx_v       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            cand_s = PTR_W'(idx_v);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Accept happens in IDLE, or in DONE when the CDB takes the result; grant only then.
    always_comb begin
        accept_s   = rst_n && win_found_s &&
                     ((state_r == IDLE) || ((state_r == DONE) && res_ready));
        next_ptr_s = (win_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                          : (win_idx_s + PTR_W'(1));
        if (accept_s) begin
            grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        end else begin
            grant = {NUM_REQ{1'b0}};
        end
    end

    // Product of the latched operands: low half, or upper half when requested.
`ifdef MULT_ARB_HIGH_EN
    always_comb begin
        full_prod_s = {{DATA_WIDTH{1'b0}}, a_r} * {{DATA_WIDTH{1'b0}}, b_r};
        if (hi_r) begin
            product_s = full_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
            product_s = full_prod_s[DATA_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        product_s = a_r * b_r;
    end
`endif

    // Next-state logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = BUSY;
                else          next_state_s = IDLE;
            end
            BUSY: begin
                if (cnt_r == CNT_W'(1)) next_state_s = DONE;
                else                    next_state_s = BUSY;
            end
            DONE: begin
                if (accept_s)       next_state_s = BUSY;
                else if (res_ready) next_state_s = IDLE;
                else                next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State, pointer, counter, operand latches and registered result port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rr_ptr_r  <= {PTR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            a_r       <= {DATA_WIDTH{1'b0}};
            b_r       <= {DATA_WIDTH{1'b0}};
            tag_r     <= {TAG_WIDTH{1'b0}};
            res_valid <= 1'b0;
            res_data  <= {DATA_WIDTH{1'b0}};
            res_tag   <= {TAG_WIDTH{1'b0}};
`ifdef MULT_ARB_HIGH_EN
            hi_r      <= 1'b0;
`endif
        end else begin
            state_r   <= next_state_s;
            res_valid <= (next_state_s == DONE);
            if (accept_s) begin
                rr_ptr_r <= next_ptr_s;
                cnt_r    <= CNT_W'(NUM_CYCLES - 1);
                a_r      <= op_a[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
                b_r      <= op_b[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
                tag_r    <= req_tag[win_idx_s*TAG_WIDTH +: TAG_WIDTH];
`ifdef MULT_ARB_HIGH_EN
                hi_r     <= req_hi[win_idx_s];
`endif
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == BUSY) && (cnt_r == CNT_W'(1))) begin
                res_data <= product_s;
                res_tag  <= tag_r;
            end else begin
                res_data <= res_data;
                res_tag  <= res_tag;
            end
        end
    end

    assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_mult_issue_arbiter.sv
// Directed self-checking bench for mult_issue_arbiter (default parameters).
// Build with MULT_ARB_HIGH_EN defined to cover the upper-half variant.
module tb_mult_issue_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int TW = 5;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  op_a;
    logic [NR*DW-1:0]  op_b;
    logic [NR*TW-1:0]  req_tag;
`ifdef MULT_ARB_HIGH_EN
    logic [NR-1:0]     req_hi;
`endif
    logic [NR-1:0]     grant;
    logic              busy;
    logic              res_valid;
    logic [DW-1:0]     res_data;
    logic [TW-1:0]     res_tag;
    logic              res_ready;

    int n_checks;
    int n_pass;

    mult_issue_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_WIDTH(TW), .NUM_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .req_tag(req_tag),
`ifdef MULT_ARB_HIGH_EN
        .req_hi(req_hi),
`endif
        .grant(grant), .busy(busy), .res_valid(res_valid),
        .res_data(res_data), .res_tag(res_tag), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [TW-1:0] t);
        op_a[i*DW +: DW]    = a;
        op_b[i*DW +: DW]    = b;
        req_tag[i*TW +: TW] = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] exp4;
    logic [NR-1:0] exp_g;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        req       = '0;
        op_a      = '0;
        op_b      = '0;
        req_tag   = '0;
        res_ready = 1'b1;
`ifdef MULT_ARB_HIGH_EN
        req_hi    = '0;
`endif
        tick();
        tick();
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data",  64'(res_data),  64'd0);
        chk("rst_res_tag",   64'(res_tag),   64'd0);
        chk("rst_grant",     64'(grant),     64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        rst_n = 1'b1;
        tick();

        // 1: single multiply 6*7, tag 3; result at T+4
        set_op(0, 32'd6, 32'd7, 5'd3);
        req = 4'b0001;
        #1;
        chk("t1_grant", 64'(grant), 64'h1);
        tick();
        req = 4'b0000;
        chk("t1_busy", 64'(busy), 64'd1);
        tick();
        tick();
        chk("t1_valid_early", 64'(res_valid), 64'd0);
        tick();
        chk("t1_valid", 64'(res_valid), 64'd1);
        chk("t1_data",  64'(res_data),  64'd42);
        chk("t1_tag",   64'(res_tag),   64'd3);
        tick();
        chk("t1_drained", 64'(res_valid), 64'd0);
        chk("t1_idle",    64'(busy),      64'd0);

        // 2: all stations held, round-robin back-to-back grants
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_op(i, 32'(i + 2), 32'd10, 5'(i + 8));
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_g = 4'b0001 << (k % 4);
            chk("t2_grant", 64'(grant), 64'(exp_g));
            if (k > 0) begin
                chk("t2_valid", 64'(res_valid), 64'd1);
                chk("t2_data",  64'(res_data),  64'((k + 1) * 10));
                chk("t2_tag",   64'(res_tag),   64'(k + 7));
            end
            tick();
            if (k == 4) begin
                req       = 4'b0000;
                res_ready = 1'b0;
            end
            chk("t2_grant_gap", 64'(grant), 64'd0);
            tick();
            tick();
            tick();
        end

        // 3: CDB backpressure for 5 cycles, then same-cycle regrant
        req = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_hold_valid", 64'(res_valid), 64'd1);
            chk("t3_hold_data",  64'(res_data),  64'd20);
            chk("t3_hold_tag",   64'(res_tag),   64'd8);
            chk("t3_hold_grant", 64'(grant),     64'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("t3_regrant", 64'(grant), 64'h4);
        tick();
        req = 4'b0000;
        chk("t3_taken", 64'(res_valid), 64'd0);
        tick();
        tick();
        tick();
        chk("t3_data", 64'(res_data), 64'd40);
        chk("t3_tag",  64'(res_tag),  64'd10);
        tick();

        // 4 + 6: overflow product; op_a changed after grant is ignored
        set_op(3, 32'hFFFF_FFFF, 32'd2, 5'd5);
`ifdef MULT_ARB_HIGH_EN
        req_hi = 4'b1000;
        exp4   = 32'h0000_0001;
`else
        exp4   = 32'hFFFF_FFFE;
`endif
        req = 4'b1000;
        #1;
        chk("t4_grant", 64'(grant), 64'h8);
        tick();
        req = 4'b0000;
        op_a[3*DW +: DW] = 32'd5;
`ifdef MULT_ARB_HIGH_EN
        req_hi = 4'b0000;
`endif
        tick();
        tick();
        tick();
        chk("t4_valid", 64'(res_valid), 64'd1);
        chk("t4_data",  64'(res_data),  64'(exp4));
        chk("t4_tag",   64'(res_tag),   64'd5);
        tick();

        // 5: reset two cycles into BUSY aborts the multiply
        set_op(1, 32'd3, 32'd3, 5'd1);
        req = 4'b0010;
        #1;
        chk("t5_grant", 64'(grant), 64'h2);
        tick();
        req = 4'b0000;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy",  64'(busy),      64'd0);
        chk("t5_rst_valid", 64'(res_valid), 64'd0);
        chk("t5_rst_data",  64'(res_data),  64'd0);
        chk("t5_rst_tag",   64'(res_tag),   64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_no_stale", 64'(res_valid), 64'd0);
        req = 4'b1000;
        #1;
        chk("t5_grant_after", 64'(grant), 64'h8);
        tick();
        req = 4'b0000;
        tick();
        tick();
        chk("t5_valid_early", 64'(res_valid), 64'd0);
        tick();
        chk("t5_valid", 64'(res_valid), 64'd1);
        chk("t5_data",  64'(res_data),  64'd10);
        chk("t5_tag",   64'(res_tag),   64'd5);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
